// File: rtl/dac_drive_5d.sv
`default_nettype none
// ============================================================================
// Module   : dac_drive_5d
// Purpose  : DAC transmit data path. Registers DAC sample words, optionally
//            converts two's complement to offset binary, and drives every bit
//            onto an LVDS pin pair through one OBUFDS. A built-in pattern
//            source and an underrun counter support board bring-up.
// Ports    : clk          - DAC sample clock, rising edge
//            rst          - asynchronous, active-high reset
//            din          - sample word (PINCOUNT bits)
//            din_valid    - din carries a new sample this cycle
//            twos         - 1: din is two's complement (MSB inverted)
//            mode         - 0=data, 1=midscale, 2=ramp, 3=toggle
//            clr_under    - synchronous clear of underrun_cnt
//            outp / outn  - LVDS positive / negative legs
//            underrun_cnt - saturating count of missed samples while armed
//            armed        - set by the first din_valid seen in mode 0
// Config   : `define DAC_PATTERN_EN enables the ramp and toggle sources.
//            Without it, modes 2 and 3 output midscale.
// Revision : 1.0 - initial release
// ============================================================================
module dac_drive_5d #(
  parameter int PINCOUNT = 16,
  parameter int UCW      = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PINCOUNT-1:0] din,
  input  logic                din_valid,
  input  logic                twos,
  input  logic [1:0]          mode,
  input  logic                clr_under,
  output logic [PINCOUNT-1:0] outp,
  output logic [PINCOUNT-1:0] outn,
  output logic [UCW-1:0]      underrun_cnt,
  output logic                armed
);

  localparam logic [1:0] c_mode_data = 2'd0;
  localparam logic [1:0] c_mode_mid  = 2'd1;
  localparam logic [1:0] c_mode_ramp = 2'd2;
  localparam logic [1:0] c_mode_tog  = 2'd3;

  localparam logic [PINCOUNT-1:0] c_midscale = {1'b1, {(PINCOUNT-1){1'b0}}};
  localparam logic [UCW-1:0]      c_cnt_max  = {UCW{1'b1}};
  localparam logic [UCW-1:0]      c_cnt_one  = {{(UCW-1){1'b0}}, 1'b1};

  logic [PINCOUNT-1:0] r_s1;
  logic [PINCOUNT-1:0] r_s2;
  logic [PINCOUNT-1:0] w_s1_next;
  logic [PINCOUNT-1:0] w_data_conv;
  logic [UCW-1:0]      r_underrun_cnt;
  logic                r_armed;
  logic                w_miss;

  // Offset binary is two's complement with the sign bit flipped.
  assign w_data_conv = twos ? {~din[PINCOUNT-1], din[PINCOUNT-2:0]} : din;

`ifdef DAC_PATTERN_EN
  localparam logic [PINCOUNT-1:0] c_ramp_one = {{(PINCOUNT-1){1'b0}}, 1'b1};

  logic [1:0]          r_mode_prev;
  logic [PINCOUNT-1:0] r_ramp;
  logic [PINCOUNT-1:0] w_ramp_cur;
  logic                r_tog;
  logic                w_tog_cur;

  // On the first cycle in a pattern mode the source restarts, so the word
  // emitted on entry is 0 for both ramp and toggle. r_mode_prev resets to
  // data mode, so a pattern mode held through reset also restarts at 0.
  assign w_ramp_cur = (r_mode_prev != c_mode_ramp) ? '0   : r_ramp;
  assign w_tog_cur  = (r_mode_prev != c_mode_tog)  ? 1'b0 : r_tog;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mode_prev <= c_mode_data;
      r_ramp      <= '0;
      r_tog       <= 1'b0;
    end else begin
      r_mode_prev <= mode;
      if (mode == c_mode_ramp) begin
        r_ramp <= w_ramp_cur + c_ramp_one;
      end
      if (mode == c_mode_tog) begin
        r_tog <= ~w_tog_cur;
      end
    end
  end

  always_comb begin
    w_s1_next = r_s1;
    case (mode)
      c_mode_data: w_s1_next = din_valid ? w_data_conv : r_s1;
      c_mode_mid:  w_s1_next = c_midscale;
      c_mode_ramp: w_s1_next = w_ramp_cur;
      c_mode_tog:  w_s1_next = {PINCOUNT{w_tog_cur}};
      default:     w_s1_next = c_midscale;
    endcase
  end
`else
  // Pattern sources are not built; every non-data mode emits midscale.
  always_comb begin
    w_s1_next = r_s1;
    case (mode)
      c_mode_data: w_s1_next = din_valid ? w_data_conv : r_s1;
      default:     w_s1_next = c_midscale;
    endcase
  end
`endif

  // s1: select/convert stage. s2: output register, intended for IOB packing.
  // Holding s1 on a missing sample avoids a glitch back to midscale.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1 <= c_midscale;
      r_s2 <= c_midscale;
    end else begin
      r_s1 <= w_s1_next;
      r_s2 <= r_s1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_armed <= 1'b0;
    end else if ((mode == c_mode_data) && din_valid) begin
      r_armed <= 1'b1;
    end
  end

  assign w_miss = r_armed && (mode == c_mode_data) && !din_valid;

  // Clear wins over increment; the count saturates at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_underrun_cnt <= '0;
    end else if (clr_under) begin
      r_underrun_cnt <= '0;
    end else if (w_miss && (r_underrun_cnt != c_cnt_max)) begin
      r_underrun_cnt <= r_underrun_cnt + c_cnt_one;
    end
  end

  assign underrun_cnt = r_underrun_cnt;
  assign armed        = r_armed;

  generate
    for (genvar gi = 0; gi < PINCOUNT; gi++) begin : g_pin
      OBUFDS u_obufds (
        .I  (r_s2[gi]),
        .O  (outp[gi]),
        .OB (outn[gi])
      );
    end
  endgenerate

endmodule

// ============================================================================
// Module   : OBUFDS
// Purpose  : Behavioural stand-in for the differential output buffer cell.
//            The vendor library cell replaces this in implementation.
// Ports    : I  - single-ended input
//            O  - positive leg
//            OB - negative leg
// Revision : 1.0 - initial release
// ============================================================================
module OBUFDS (
  input  logic I,
  output logic O,
  output logic OB
);
  assign O  = I;
  assign OB = ~I;
endmodule
`default_nettype wire

// File: tb/tb_dac_drive_5d.sv
`default_nettype none
// ============================================================================
// Module   : tb_dac_drive_5d
// Purpose  : Directed, self-checking bench for dac_drive_5d (PINCOUNT=16,
//            UCW=4). Expected pin values follow DAC_PATTERN_EN when defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dac_drive_5d;

  localparam int P = 16;
  localparam int U = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [P-1:0] din = '0;
  logic         din_valid = 1'b0;
  logic         twos = 1'b0;
  logic [1:0]   mode = 2'd0;
  logic         clr_under = 1'b0;
  logic [P-1:0] outp;
  logic [P-1:0] outn;
  logic [U-1:0] underrun_cnt;
  logic         armed;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dac_drive_5d #(.PINCOUNT(P), .UCW(U)) dut (
    .clk          (clk),
    .rst          (rst),
    .din          (din),
    .din_valid    (din_valid),
    .twos         (twos),
    .mode         (mode),
    .clr_under    (clr_under),
    .outp         (outp),
    .outn         (outn),
    .underrun_cnt (underrun_cnt),
    .armed        (armed)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_pins(input string tag, input logic [P-1:0] exp);
    logic [P-1:0] inv;
    inv = ~exp;
    chk({tag, "_outp"}, {16'h0, outp}, {16'h0, exp});
    chk({tag, "_outn"}, {16'h0, outn}, {16'h0, inv});
  endtask

  // Expected pin word in a pattern mode: the pattern value, or midscale
  // when the pattern sources are not built.
  function automatic logic [P-1:0] pat(input logic [P-1:0] v);
`ifdef DAC_PATTERN_EN
    return v;
`else
    return 16'h8000;
`endif
  endfunction

  initial begin
    logic [P-1:0] exp_r;
    int           bad;

    // Reset state
    repeat (2) tick();
    chk_pins("rst", 16'h8000);
    chk("rst_armed", {31'h0, armed}, 32'd0);
    chk("rst_cnt", {28'h0, underrun_cnt}, 32'd0);
    rst = 1'b0;

    // Not armed yet: a missing sample does not count
    tick();
    chk("unarmed_cnt", {28'h0, underrun_cnt}, 32'd0);
    chk_pins("idle", 16'h8000);

    // Two-edge latency
    din = 16'h1234; din_valid = 1'b1;
    tick();
    chk_pins("lat_e1", 16'h8000);
    chk("armed_set", {31'h0, armed}, 32'd1);
    din_valid = 1'b0;
    tick();
    chk_pins("lat_e2", 16'h1234);
    chk("cnt_first_miss", {28'h0, underrun_cnt}, 32'd1);

    // Two's complement to offset binary
    twos = 1'b1; din = 16'hFFFF; din_valid = 1'b1;
    tick();
    din = 16'h8000;
    tick();
    chk_pins("twos_m1", 16'h7FFF);
    din_valid = 1'b0;
    tick();
    chk_pins("twos_min", 16'h0000);
    chk("cnt_two", {28'h0, underrun_cnt}, 32'd2);

    // Clear during a miss cycle wins
    clr_under = 1'b1;
    tick();
    clr_under = 1'b0;
    chk("clr_miss", {28'h0, underrun_cnt}, 32'd0);

    // Five misses, output holds
    repeat (5) tick();
    chk("cnt_five", {28'h0, underrun_cnt}, 32'd5);
    chk_pins("hold", 16'h0000);

    // Saturation at 15
    repeat (20) tick();
    chk("cnt_sat", {28'h0, underrun_cnt}, 32'd15);

    // Midscale mode: counter frozen, din ignored
    mode = 2'd1;
    tick();
    chk_pins("mid_e1", 16'h0000);
    tick();
    chk_pins("mid_e2", 16'h8000);
    twos = 1'b0; din = 16'h1234; din_valid = 1'b1;
    repeat (3) tick();
    chk_pins("mid_ign", 16'h8000);
    din_valid = 1'b0;
    tick();
    chk("cnt_frozen", {28'h0, underrun_cnt}, 32'd15);
    clr_under = 1'b1;
    tick();
    clr_under = 1'b0;
    chk("clr_mid", {28'h0, underrun_cnt}, 32'd0);

    // Ramp with wrap
    mode = 2'd2;
    tick();
    tick();
    chk_pins("ramp_start", pat(16'h0000));
    exp_r = 16'h0000;
    bad = 0;
    for (int k = 1; k <= 65540; k++) begin
      tick();
      exp_r = exp_r + 16'h0001;
      if (outp !== pat(exp_r) || outn !== ~pat(exp_r)) bad++;
      if (k == 65535) chk_pins("ramp_ffff", pat(16'hFFFF));
      if (k == 65536) chk_pins("ramp_wrap", pat(16'h0000));
    end
    chk("ramp_seq_errs", bad, 32'd0);
    chk_pins("ramp_end", pat(16'h0004));

    // Toggle, starting with 0
    mode = 2'd3;
    tick();
    chk_pins("tog_e1", pat(16'h0005));
    tick();
    chk_pins("tog_0a", pat(16'h0000));
    tick();
    chk_pins("tog_1a", pat(16'hFFFF));
    tick();
    chk_pins("tog_0b", pat(16'h0000));
    tick();
    chk_pins("tog_1b", pat(16'hFFFF));

    // Misses count again in data mode, then async reset mid-ramp
    mode = 2'd0; din_valid = 1'b0;
    repeat (2) tick();
    chk("cnt_resume", {28'h0, underrun_cnt}, 32'd2);
    mode = 2'd2;
    repeat (3) tick();
    chk_pins("ramp2", pat(16'h0001));
    chk("cnt_ramp_frozen", {28'h0, underrun_cnt}, 32'd2);
    #2;
    rst = 1'b1;
    #1;
    chk_pins("async_rst", 16'h8000);
    chk("async_armed", {31'h0, armed}, 32'd0);
    chk("async_cnt", {28'h0, underrun_cnt}, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    chk_pins("rel_e1", 16'h8000);
    tick();
    chk_pins("rel_e2", pat(16'h0000));
    tick();
    chk_pins("rel_e3", pat(16'h0001));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
